// File: rtl/uart_bus_master_if.sv
// rtl/uart_bus_master_if.sv - valid/ready memory bus driven by the UART bus master
interface uart_bus_master_if;
  logic [31:0] addr;
  logic [2:0]  size;
  logic        valid;
  logic        write;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (
    output addr, size, valid, write, wdata,
    input  rdata, ready
  );

  modport slave (
    input  addr, size, valid, write, wdata,
    output rdata, ready
  );
endinterface

// File: rtl/uart_bus_master.sv
// rtl/uart_bus_master.sv - 8N1 serial command bridge issuing single-word bus reads/writes
module uart_bus_master #(
  parameter int unsigned CLKDIV       = 400,
  parameter int unsigned BYTE_TIMEOUT = 2000000,
  parameter int unsigned BUS_TIMEOUT  = 1024,
  parameter logic        HOLD_RST     = 1'b1
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                rx,
  output logic                tx,
  output logic                hold,
  output logic                busy,
  uart_bus_master_if.master   bus
);

  localparam logic [15:0] DIV_M1  = 16'(CLKDIV - 1);
  localparam logic [15:0] HALF_M1 = 16'(CLKDIV / 2 - 1);
  localparam logic [31:0] BYTE_TO = 32'(BYTE_TIMEOUT - 1);
  localparam logic [31:0] BUS_TO  = 32'(BUS_TIMEOUT - 1);

  localparam logic [7:0] CH_W = 8'h57, CH_R = 8'h52, CH_H = 8'h48, CH_G = 8'h47;
  localparam logic [7:0] CH_K = 8'h4B, CH_E = 8'h45, CH_Q = 8'h3F;

  // ---------------- RX ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t   rx_state, rx_state_n;
  logic [15:0] rx_cnt, rx_cnt_n;
  logic [2:0]  rx_bit, rx_bit_n;
  logic [7:0]  rx_sh, rx_sh_n;
  logic        rx_stb, rx_stb_n;
  logic        rx_meta, rx_sync, rx_prev;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_stb   <= 1'b0;
    end else begin
      rx_meta  <= rx;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_sh    <= rx_sh_n;
      rx_stb   <= rx_stb_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_sh_n    = rx_sh;
    rx_stb_n   = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_sync) begin
          rx_state_n = RX_START;
          rx_cnt_n   = HALF_M1;
        end
      end
      RX_START: begin
        if (rx_cnt != 16'd0) begin
          rx_cnt_n = rx_cnt - 16'd1;
        end else if (rx_sync) begin
          rx_state_n = RX_IDLE;
        end else begin
          rx_state_n = RX_DATA;
          rx_cnt_n   = DIV_M1;
          rx_bit_n   = 3'd0;
        end
      end
      RX_DATA: begin
        if (rx_cnt != 16'd0) begin
          rx_cnt_n = rx_cnt - 16'd1;
        end else begin
          rx_sh_n  = {rx_sync, rx_sh[7:1]};
          rx_cnt_n = DIV_M1;
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
          else                rx_bit_n   = rx_bit + 3'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt != 16'd0) begin
          rx_cnt_n = rx_cnt - 16'd1;
        end else begin
          // A low stop bit silently drops the byte.
          rx_stb_n   = rx_sync;
          rx_state_n = RX_IDLE;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // ---------------- TX ----------------
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  tx_state_t   tx_state, tx_state_n;
  logic [15:0] tx_cnt, tx_cnt_n;
  logic [3:0]  tx_bit, tx_bit_n;
  logic [8:0]  tx_sh, tx_sh_n;
  logic        tx_n;
  logic        slot_full, slot_full_n;
  logic [7:0]  slot_data, slot_data_n;
  logic        tx_load;
  logic [7:0]  tx_byte;
  logic        start_frame;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      tx_state  <= TX_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_sh     <= '1;
      tx        <= 1'b1;
      slot_full <= 1'b0;
      slot_data <= '0;
    end else begin
      tx_state  <= tx_state_n;
      tx_cnt    <= tx_cnt_n;
      tx_bit    <= tx_bit_n;
      tx_sh     <= tx_sh_n;
      tx        <= tx_n;
      slot_full <= slot_full_n;
      slot_data <= slot_data_n;
    end
  end

  always_comb begin
    tx_state_n  = tx_state;
    tx_cnt_n    = tx_cnt;
    tx_bit_n    = tx_bit;
    tx_sh_n     = tx_sh;
    tx_n        = tx;
    slot_full_n = slot_full;
    slot_data_n = slot_data;
    start_frame = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (slot_full) start_frame = 1'b1;
      end
      TX_SEND: begin
        if (tx_cnt != 16'd0) begin
          tx_cnt_n = tx_cnt - 16'd1;
        end else if (tx_bit == 4'd9) begin
          // End of stop bit: chain straight into the next byte if one is waiting.
          if (slot_full) begin
            start_frame = 1'b1;
          end else begin
            tx_n       = 1'b1;
            tx_state_n = TX_IDLE;
          end
        end else begin
          tx_n     = tx_sh[0];
          tx_sh_n  = {1'b1, tx_sh[8:1]};
          tx_bit_n = tx_bit + 4'd1;
          tx_cnt_n = DIV_M1;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
    if (start_frame) begin
      tx_n        = 1'b0;
      tx_sh_n     = {1'b1, slot_data};
      tx_bit_n    = 4'd0;
      tx_cnt_n    = DIV_M1;
      tx_state_n  = TX_SEND;
      slot_full_n = 1'b0;
    end
    if (tx_load) begin
      slot_full_n = 1'b1;
      slot_data_n = tx_byte;
    end
  end

  // ---------------- Parser ----------------
  typedef enum logic [2:0] {P_IDLE, P_ADDR, P_DATA, P_BUS, P_REPLY} p_state_t;

  p_state_t    p_state, p_state_n;
  logic [1:0]  idx, idx_n;
  logic [31:0] tmo, tmo_n;
  logic [31:0] addr_q, addr_n;
  logic [31:0] wdata_q, wdata_n;
  logic        write_q, write_n;
  logic        valid_q, valid_n;
  logic        hold_q, hold_n;
  logic [39:0] rep_buf, rep_buf_n;
  logic [2:0]  rep_cnt, rep_cnt_n;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      p_state <= P_IDLE;
      idx     <= '0;
      tmo     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      valid_q <= 1'b0;
      hold_q  <= HOLD_RST;
      rep_buf <= '0;
      rep_cnt <= '0;
    end else begin
      p_state <= p_state_n;
      idx     <= idx_n;
      tmo     <= tmo_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      write_q <= write_n;
      valid_q <= valid_n;
      hold_q  <= hold_n;
      rep_buf <= rep_buf_n;
      rep_cnt <= rep_cnt_n;
    end
  end

  always_comb begin
    p_state_n = p_state;
    idx_n     = idx;
    tmo_n     = tmo;
    addr_n    = addr_q;
    wdata_n   = wdata_q;
    write_n   = write_q;
    valid_n   = valid_q;
    hold_n    = hold_q;
    rep_buf_n = rep_buf;
    rep_cnt_n = rep_cnt;
    tx_load   = 1'b0;
    tx_byte   = rep_buf[7:0];
    case (p_state)
      P_IDLE: begin
        idx_n = 2'd0;
        tmo_n = '0;
        if (rx_stb) begin
          p_state_n = P_REPLY;
          rep_cnt_n = 3'd1;
          rep_buf_n = {32'd0, CH_K};
          case (rx_sh)
            CH_W: begin write_n = 1'b1; p_state_n = P_ADDR; end
            CH_R: begin write_n = 1'b0; p_state_n = P_ADDR; end
            CH_H: hold_n = 1'b1;
            CH_G: hold_n = 1'b0;
            default: rep_buf_n = {32'd0, CH_Q};
          endcase
        end
      end
      P_ADDR, P_DATA: begin
        if (rx_stb) begin
          tmo_n = '0;
          idx_n = idx + 2'd1;
          if (p_state == P_ADDR) addr_n  = {rx_sh, addr_q[31:8]};
          else                   wdata_n = {rx_sh, wdata_q[31:8]};
          if (idx == 2'd3) begin
            if (p_state == P_ADDR && write_q) begin
              p_state_n = P_DATA;
            end else begin
              p_state_n = P_BUS;
              valid_n   = 1'b1;
            end
          end
        end else if (tmo == BYTE_TO) begin
          p_state_n = P_IDLE;
        end else begin
          tmo_n = tmo + 32'd1;
        end
      end
      P_BUS: begin
        if (bus.ready) begin
          valid_n   = 1'b0;
          p_state_n = P_REPLY;
          rep_buf_n = write_q ? {32'd0, CH_K} : {bus.rdata, CH_K};
          rep_cnt_n = write_q ? 3'd1 : 3'd5;
        end else if (tmo == BUS_TO) begin
          valid_n   = 1'b0;
          p_state_n = P_REPLY;
          rep_buf_n = {32'd0, CH_E};
          rep_cnt_n = 3'd1;
        end else begin
          tmo_n = tmo + 32'd1;
        end
      end
      P_REPLY: begin
        if (rep_cnt == 3'd0) begin
          p_state_n = P_IDLE;
        end else if (!slot_full) begin
          tx_load   = 1'b1;
          rep_buf_n = {8'd0, rep_buf[39:8]};
          rep_cnt_n = rep_cnt - 3'd1;
        end
      end
      default: p_state_n = P_IDLE;
    endcase
  end

  assign busy      = (p_state != P_IDLE);
  assign hold      = hold_q;
  assign bus.addr  = addr_q;
  assign bus.wdata = wdata_q;
  assign bus.write = write_q;
  assign bus.valid = valid_q;
  assign bus.size  = 3'd2;

endmodule

// File: tb/tb_uart_bus_master.sv
// tb/tb_uart_bus_master.sv - directed bench for uart_bus_master with a tx-byte scoreboard
module tb_uart_bus_master;
  localparam int CLKDIV = 8;
  localparam int BTO    = 300;
  localparam int BUSTO  = 16;

  logic clk  = 1'b0;
  logic rstb = 1'b0;
  logic rx   = 1'b1;
  logic tx, hold, busy;

  uart_bus_master_if bus ();

  uart_bus_master #(
    .CLKDIV(CLKDIV), .BYTE_TIMEOUT(BTO), .BUS_TIMEOUT(BUSTO), .HOLD_RST(1'b1)
  ) dut (
    .clk(clk), .rstb(rstb), .rx(rx), .tx(tx), .hold(hold), .busy(busy), .bus(bus.master)
  );

  always #5 clk = ~clk;

  // Responder: mode 0 never ready, 1 ready same cycle as valid, 2 ready two cycles after valid.
  int          mode = 0;
  int          vdly = 0;
  logic [31:0] rdata_drv = '0;

  always @(posedge clk) vdly <= (bus.valid && !bus.ready) ? vdly + 1 : 0;

  always_comb begin
    bus.ready = 1'b0;
    case (mode)
      1:       bus.ready = bus.valid;
      2:       bus.ready = bus.valid && (vdly >= 2);
      default: bus.ready = 1'b0;
    endcase
  end
  assign bus.rdata = rdata_drv;

  int          hs = 0, vcyc = 0;
  logic [31:0] h_addr = '0, h_wdata = '0;
  logic        h_write = 1'b0;
  logic [2:0]  h_size = '0;

  always @(posedge clk) begin
    if (bus.valid) vcyc <= vcyc + 1;
    if (bus.valid && bus.ready) begin
      hs      <= hs + 1;
      h_addr  <= bus.addr;
      h_wdata <= bus.wdata;
      h_write <= bus.write;
      h_size  <= bus.size;
    end
  end

  // Serial decoder on tx; frames interrupted by reset are discarded.
  logic [8:0] got_q[$];
  logic [7:0] exp_q[$];
  logic       mon_busy = 1'b0;

  initial begin : tx_mon
    logic [7:0] b;
    logic       ok;
    forever begin
      @(negedge clk);
      if (rstb === 1'b1 && tx === 1'b0) begin
        ok = 1'b1;
        mon_busy = 1'b1;
        for (int i = 0; i < CLKDIV / 2; i++) begin @(negedge clk); if (!rstb) ok = 1'b0; end
        for (int k = 0; k < 8; k++) begin
          for (int i = 0; i < CLKDIV; i++) begin @(negedge clk); if (!rstb) ok = 1'b0; end
          b[k] = tx;
        end
        for (int i = 0; i < CLKDIV; i++) begin @(negedge clk); if (!rstb) ok = 1'b0; end
        if (ok) got_q.push_back({tx, b});
        mon_busy = 1'b0;
      end
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    rx = 1'b0;
    repeat (CLKDIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CLKDIV) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CLKDIV) @(negedge clk);
    rx = 1'b1;
    if (!stop_bit) repeat (CLKDIV) @(negedge clk);
  endtask

  // Pops every decoded tx byte against the scoreboard until all expected bytes arrive.
  task automatic drain(input int limit);
    int         n;
    logic [8:0] g;
    logic [9:0] e;
    n = 0;
    while ((exp_q.size() > 0 || got_q.size() > 0 || mon_busy) && n < limit) begin
      @(negedge clk);
      n++;
      while (got_q.size() > 0) begin
        g = got_q.pop_front();
        e = (exp_q.size() > 0) ? {2'b01, exp_q.pop_front()} : 10'h200;
        chk("tx_byte", 64'({1'b0, g}), 64'(e));
      end
    end
    chk("tx_all_received", 64'(exp_q.size()), 64'd0);
  endtask

  int base_hs, base_v, n;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tx",    64'(tx),        64'd1);
    chk("rst_valid", 64'(bus.valid), 64'd0);
    chk("rst_write", 64'(bus.write), 64'd0);
    chk("rst_addr",  64'(bus.addr),  64'd0);
    chk("rst_wdata", 64'(bus.wdata), 64'd0);
    chk("rst_size",  64'(bus.size),  64'd2);
    chk("rst_busy",  64'(busy),      64'd0);
    chk("rst_hold",  64'(hold),      64'd1);
    rstb = 1'b1;
    repeat (4) @(negedge clk);

    // 1: reset while a reply byte is on the line
    send_byte(8'h48);
    n = 0;
    while (tx !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
    chk("t1_tx_started", 64'(n < 2000), 64'd1);
    repeat (20) @(negedge clk);
    rstb = 1'b0;
    #1;
    chk("t1_tx_idle",  64'(tx),        64'd1);
    chk("t1_valid",    64'(bus.valid), 64'd0);
    chk("t1_hold",     64'(hold),      64'd1);
    chk("t1_busy",     64'(busy),      64'd0);
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    repeat (150) @(negedge clk);
    drain(10);

    // 2: write with a responder that waits two cycles
    mode = 2;
    base_hs = hs;
    exp_q.push_back(8'h4B);
    send_byte(8'h57);
    send_byte(8'h00); send_byte(8'h10); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    drain(3000);
    chk("t2_handshakes", 64'(hs - base_hs), 64'd1);
    chk("t2_addr",       64'(h_addr),       64'h1000);
    chk("t2_write",      64'(h_write),      64'd1);
    chk("t2_wdata",      64'(h_wdata),      64'hDEADBEEF);
    chk("t2_size",       64'(h_size),       64'd2);

    // 3: read with same-cycle ready
    mode = 1;
    rdata_drv = 32'h12345678;
    base_hs = hs;
    base_v  = vcyc;
    exp_q.push_back(8'h4B); exp_q.push_back(8'h78); exp_q.push_back(8'h56);
    exp_q.push_back(8'h34); exp_q.push_back(8'h12);
    send_byte(8'h52);
    send_byte(8'h08); send_byte(8'h30); send_byte(8'h00); send_byte(8'h00);
    drain(4000);
    chk("t3_handshakes",  64'(hs - base_hs),  64'd1);
    chk("t3_valid_cycles", 64'(vcyc - base_v), 64'd1);
    chk("t3_addr",        64'(h_addr),        64'h3008);
    chk("t3_write",       64'(h_write),       64'd0);

    // 4: read that never completes, then release hold
    mode = 0;
    base_hs = hs;
    base_v  = vcyc;
    exp_q.push_back(8'h45);
    send_byte(8'h52);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h40);
    drain(3000);
    chk("t4_valid_cycles", 64'(vcyc - base_v), 64'd16);
    chk("t4_handshakes",   64'(hs - base_hs),  64'd0);
    chk("t4_valid_low",    64'(bus.valid),     64'd0);
    exp_q.push_back(8'h4B);
    send_byte(8'h47);
    drain(2000);
    chk("t4_hold", 64'(hold), 64'd0);

    // 5: framing error is ignored, unknown command answered with '?'
    send_byte(8'h00, 1'b0);
    repeat (200) @(negedge clk);
    drain(10);
    chk("t5_busy", 64'(busy), 64'd0);
    exp_q.push_back(8'h3F);
    send_byte(8'h5A);
    drain(2000);

    // 6: inter-byte timeout abandons a partial write
    base_hs = hs;
    send_byte(8'h57);
    send_byte(8'h00); send_byte(8'h10);
    repeat (20) @(negedge clk);
    chk("t6_busy_waiting", 64'(busy), 64'd1);
    repeat (BTO + 20) @(negedge clk);
    chk("t6_busy_timeout", 64'(busy),         64'd0);
    chk("t6_no_bus_cycle", 64'(hs - base_hs), 64'd0);
    drain(10);
    exp_q.push_back(8'h4B);
    send_byte(8'h48);
    drain(2000);
    chk("t6_hold", 64'(hold), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_bus_master.md
Name: uart_bus_master

Overview:
- Serial debug/loader bridge that acts as a bus initiator on the same valid/ready memory bus the CPU core drives.
- Receives 8N1 command frames from a host, issues single-word reads and writes to RAM or peripherals, and returns results over a serial transmit line.
- Provides a `hold` output so the host can keep the CPU core out of the bus while it loads memory.
- Top-level arbitration between this block and the core is outside this block; `hold` is the only coordination signal.

Parameters:
- CLKDIV, 400, clock cycles per UART bit (200 MHz / 500 kbaud); legal range 4..65535.
- BYTE_TIMEOUT, 'd2000000, idle cycles between bytes of one command before the parser aborts to IDLE.
- BUS_TIMEOUT, 'd1024, cycles `valid` may wait for `ready` before the transaction is abandoned.
- HOLD_RST, 1'b1, value of `hold` after reset.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rstb  in  1  asynchronous active-low reset.
- rx  in  1  serial in, idle high, asynchronous to clk.
- tx  out  1  serial out, idle high.
- hold  out  1  1 = the CPU must stay idle and the bus is owned by this block.
- busy  out  1  1 = parser is not in IDLE.
- addr  out  32  bus byte address.
- size  out  3  transfer size, fixed 3'd2 (word).
- valid  out  1  bus request.
- write  out  1  1 = write, 0 = read.
- wdata  out  32  write data.
- rdata  in  32  read data, sampled when valid&&ready.
- ready  in  1  responder completion.

Behaviour:

Reset (rstb low, asynchronous):
- tx=1, valid=0, write=0, addr=0, wdata=0, size=2, busy=0, hold=HOLD_RST.
- All FSMs return to IDLE.
- A reset in the middle of a byte or a bus transaction discards it; no reply is sent.

RX path:
- rx passes through a 2-flop synchronizer.
- A falling edge in idle starts a frame. The start bit is re-checked at CLKDIV/2 and the frame is aborted if rx is high.
- Data bits are sampled every CLKDIV cycles from there, LSB first.
- Stop bit = 0 → framing error: the byte is dropped and the parser is not advanced.
- Each accepted byte produces a 1-cycle strobe to the parser.

TX path:
- 8N1, LSB first, CLKDIV cycles per bit.
- One 1-deep holding slot. The parser only loads a byte when the slot is empty.
- Back-to-back bytes are sent with no idle gap beyond the stop bit.

Parser FSM states: IDLE, ADDR, DATA, BUS, REPLY.
- IDLE, cmd byte:
  - 'W' (0x57) → ADDR, then DATA.
  - 'R' (0x52) → ADDR, then BUS.
  - 'H' (0x48) → hold=1, reply 'K'.
  - 'G' (0x47) → hold=0, reply 'K'.
  - Any other byte → reply '?' (0x3F).
- ADDR: collect 4 bytes, little-endian, into addr. DATA: collect 4 bytes, little-endian, into wdata.
- BUS: assert valid with addr/write/wdata held stable.
  - The transaction completes on the first posedge where valid&&ready, including the very first cycle.
  - valid drops on the next cycle. rdata is captured on that same edge.
  - No address alignment check; addr[1:0] is forwarded as received.
- REPLY:
  - Write → 'K' (0x4B).
  - Read → 'K' followed by rdata as 4 bytes, LSB first.
  - BUS_TIMEOUT expiry → valid=0, reply 'E' (0x45), no data bytes.
- Inter-byte timeout: in ADDR or DATA, BYTE_TIMEOUT cycles without a byte → IDLE silently.
- Bytes arriving during BUS or REPLY are discarded. The host must wait for the full reply.
- `hold` is not forced by W or R; issuing them while hold=0 is the host's responsibility.
- busy=1 in every state except IDLE.

Test Plan (CLKDIV=8, BUS_TIMEOUT=16):
1. Reset mid-tx-byte → tx=1 on the same cycle; valid=0; hold=1.
2. Send 'W',00,10,00,00,EF,BE,AD,DE; responder ready=1 two cycles after valid → exactly one valid&&ready with addr=0x1000, write=1, wdata=0xDEADBEEF, size=2; tx emits 0x4B.
3. Send 'R',08,30,00,00 with rdata=0x12345678 and ready combinational on the same cycle → valid high exactly 1 cycle; tx emits 4B,78,56,34,12.
4. 'R' to an address whose ready never rises → valid drops after 16 cycles; tx emits 0x45; the next 'G' is answered with 0x4B and hold=0.
5. Byte 0x00 with stop bit driven low → no reply, parser stays IDLE; then 'Z' → tx emits 0x3F.
6. 'W' plus 2 address bytes, then silence for BYTE_TIMEOUT → busy falls to 0, no bus cycle; a following 'H' → 0x4B, hold=1.
